// File: rtl/bist_checker.sv
// bist_checker: self-test controller and verdict block for the radix-4 multiplier BIST wrapper.
// Counts wrapper vector completions (rising edges of ready_in) and captures the final MISR
// signature. The signature is then compared against GOLDEN.
// Optional feature: define BIST_CHECKER_TIMEOUT_EN to compile in the inter-vector watchdog.
// Without it, timeout_err is tied low and RUN waits for edges indefinitely.
module bist_checker #(
  parameter int unsigned N_VECTORS = 64,
  parameter logic [15:0] GOLDEN    = 16'h0000,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        ready_in,
  input  logic [15:0] result_in,
  output logic        test_en,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [15:0] signature,
  output logic [7:0]  vec_count
);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  localparam logic [7:0] LastVec = 8'(N_VECTORS - 1);

  state_e      state_q, state_d;
  logic        ready_q;
  logic        rdy_edge;
  logic        test_en_q, test_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] sig_q, sig_d;
  logic [7:0]  vec_q, vec_d;

`ifdef BIST_CHECKER_TIMEOUT_EN
  // Timeout fires on the cycle the watchdog would step to TIMEOUT-1, so done lands at e+TIMEOUT.
  localparam logic [15:0] WdLimit = 16'(TIMEOUT - 2);
  logic [15:0] wd_q, wd_d;
  logic        tmo_q, tmo_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // A level held high counts as a single vector completion.
  assign rdy_edge = ready_in & ~ready_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    test_en_d = test_en_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    sig_d     = sig_q;
    vec_d     = vec_q;
`ifdef BIST_CHECKER_TIMEOUT_EN
    wd_d      = wd_q;
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (run) begin
          state_d   = StRun;
          vec_d     = 8'd0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          sig_d     = 16'd0;
          test_en_d = 1'b1;
          busy_d    = 1'b1;
`ifdef BIST_CHECKER_TIMEOUT_EN
          wd_d      = 16'd0;
          tmo_d     = 1'b0;
`endif
        end
      end
      StRun: begin
        // An edge always beats the watchdog limit in the same cycle.
        if (rdy_edge) begin
          vec_d = vec_q + 8'd1;
`ifdef BIST_CHECKER_TIMEOUT_EN
          wd_d  = 16'd0;
`endif
          if (vec_q == LastVec) begin
            sig_d   = result_in;
            state_d = StCheck;
          end
        end
`ifdef BIST_CHECKER_TIMEOUT_EN
        else if (wd_q == WdLimit) begin
          state_d   = StDone;
          done_d    = 1'b1;
          pass_d    = 1'b0;
          tmo_d     = 1'b1;
          test_en_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      StCheck: begin
        pass_d    = (sig_q == GOLDEN);
        done_d    = 1'b1;
        test_en_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ready_q   <= 1'b0;
      test_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      sig_q     <= 16'd0;
      vec_q     <= 8'd0;
`ifdef BIST_CHECKER_TIMEOUT_EN
      wd_q      <= 16'd0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_in;
      test_en_q <= test_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      sig_q     <= sig_d;
      vec_q     <= vec_d;
`ifdef BIST_CHECKER_TIMEOUT_EN
      wd_q      <= wd_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign test_en   = test_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = vec_q;
`ifdef BIST_CHECKER_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bist_checker.sv
// tb_bist_checker: directed bench for bist_checker (N_VECTORS=4, GOLDEN=16'hBEEF, TIMEOUT=20).
// The timeout step follows BIST_CHECKER_TIMEOUT_EN when that macro is defined for the build.
module tb_bist_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        ready_in;
  logic [15:0] result_in;
  logic        test_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [15:0] signature;
  logic [7:0]  vec_count;

  int total = 0;
  int bad   = 0;

  bist_checker #(
    .N_VECTORS(4),
    .GOLDEN   (16'hBEEF),
    .TIMEOUT  (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .ready_in   (ready_in),
    .result_in  (result_in),
    .test_en    (test_en),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout_err(timeout_err),
    .signature  (signature),
    .vec_count  (vec_count)
  );

  always #5 clk = ~clk;

  // Advance one clock, then sample away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // One-cycle ready pulse; the edge is sampled at the clock inside this task.
  task automatic pulse(input logic [15:0] res);
    result_in = res;
    ready_in  = 1'b1;
    tick();
    ready_in  = 1'b0;
  endtask

  // Four pulses spaced 5 cycles apart; the final result is presented with the 4th edge.
  task automatic four_vectors(input logic [15:0] res);
    for (int i = 0; i < 4; i++) begin
      pulse((i == 3) ? res : 16'h1234);
      chk("vec_step", 32'(vec_count), 32'(i + 1));
      if (i < 3) repeat (4) tick();
    end
  endtask

  initial begin
    logic seen_done;
    reset     = 1'b1;
    run       = 1'b0;
    ready_in  = 1'b0;
    result_in = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_test_en", 32'(test_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_sig", 32'(signature), 32'd0);
    chk("rst_vec", 32'(vec_count), 32'd0);

    // Pass case.
    start();
    chk("run_test_en", 32'(test_en), 32'd1);
    chk("run_busy", 32'(busy), 32'd1);
    four_vectors(16'hBEEF);
    chk("check_sig", 32'(signature), 32'hBEEF);
    chk("check_done", 32'(done), 32'd0);
    chk("check_busy", 32'(busy), 32'd1);
    tick();
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_pass", 32'(pass), 32'd1);
    chk("pass_sig", 32'(signature), 32'hBEEF);
    chk("pass_vec", 32'(vec_count), 32'd4);
    chk("pass_test_en", 32'(test_en), 32'd0);
    chk("pass_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_pass", 32'(pass), 32'd1);

    // Restart from DONE, second passing run.
    start();
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_pass", 32'(pass), 32'd0);
    chk("rs_test_en", 32'(test_en), 32'd1);
    chk("rs_vec", 32'(vec_count), 32'd0);
    chk("rs_sig", 32'(signature), 32'd0);
    four_vectors(16'hBEEF);
    tick();
    chk("rs2_done", 32'(done), 32'd1);
    chk("rs2_pass", 32'(pass), 32'd1);

    // Fail case.
    start();
    four_vectors(16'hBEEE);
    tick();
    chk("fail_done", 32'(done), 32'd1);
    chk("fail_pass", 32'(pass), 32'd0);
    chk("fail_sig", 32'(signature), 32'hBEEE);
    chk("fail_tmo", 32'(timeout_err), 32'd0);

    // Held ready counts once.
    start();
    result_in = 16'h1234;
    ready_in  = 1'b1;
    repeat (10) tick();
    ready_in = 1'b0;
    chk("held_vec", 32'(vec_count), 32'd1);
    tick();
    pulse(16'h1234);
    chk("held_vec2", 32'(vec_count), 32'd2);
    repeat (4) tick();
    pulse(16'h1234);
    chk("held_vec3", 32'(vec_count), 32'd3);
    chk("held_nodone", 32'(done), 32'd0);
    repeat (4) tick();
    pulse(16'hBEEF);
    chk("held_vec4", 32'(vec_count), 32'd4);
    tick();
    chk("held_done", 32'(done), 32'd1);
    chk("held_pass", 32'(pass), 32'd1);

    // Timeout: two edges then silence.
    start();
    pulse(16'h1234);
    repeat (4) tick();
    pulse(16'h1234);
    chk("to_vec2", 32'(vec_count), 32'd2);
`ifdef BIST_CHECKER_TIMEOUT_EN
    repeat (18) tick();
    chk("to_early", 32'(done), 32'd0);
    tick();
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_pass", 32'(pass), 32'd0);
    chk("to_vec", 32'(vec_count), 32'd2);
    chk("to_test_en", 32'(test_en), 32'd0);
`else
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      seen_done = seen_done | done;
    end
    chk("noto_done", 32'(seen_done), 32'd0);
    chk("noto_busy", 32'(busy), 32'd1);
    chk("noto_err", 32'(timeout_err), 32'd0);
`endif

    // Reset mid-run.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start();
    pulse(16'h1234);
    repeat (4) tick();
    pulse(16'h1234);
    chk("mid_vec", 32'(vec_count), 32'd2);
    chk("mid_test_en", 32'(test_en), 32'd1);
    reset = 1'b1;
    run   = 1'b1;
    tick();
    reset = 1'b0;
    run   = 1'b0;
    chk("mrst_test_en", 32'(test_en), 32'd0);
    chk("mrst_vec", 32'(vec_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    tick();
    chk("mrst_idle", 32'(busy), 32'd0);

    // Recovery after reset.
    start();
    four_vectors(16'hBEEF);
    tick();
    chk("rec_done", 32'(done), 32'd1);
    chk("rec_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
